// File: rtl/lab1_imul_dot_accum.sv
// rtl/lab1_imul_dot_accum.sv - dot-product reduction stage behind the lab1 integer multiplier
//
// Sums each group of p_nterms consecutive 32-bit products and emits one
// {carry, sum} message per group. The carry bit is sticky across the group.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset
//   in_val   - product valid (multiplier resp_val)
//   in_rdy   - stage can accept a product (multiplier resp_rdy)
//   in_msg   - 32-bit product (multiplier result field)
//   out_val  - group sum valid
//   out_rdy  - consumer ready
//   out_msg  - {carry, sum[31:0]}

module lab1_imul_dot_accum #(
  parameter int p_nterms = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_msg,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [32:0] out_msg
);

  // One extra bit so the counter can hold p_nterms itself for p_nterms = 2^k.
  localparam int               cnt_w    = $clog2(p_nterms) + 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_nterms - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [31:0]       acc_q,     acc_d;
  logic              cry_q,     cry_d;
  logic [cnt_w-1:0]  cnt_q,     cnt_d;
  logic              out_val_q, out_val_d;
  logic [32:0]       out_msg_q, out_msg_d;

  logic              in_go;
  logic              out_go;
  logic [32:0]       sum;

  // In DONE the stage forwards consumer readiness upstream so the first
  // product of the next group can be taken on the same edge the sum leaves.
  assign in_rdy  = !reset && ((state_q == ST_ACCUM) || out_rdy);
  assign out_val = out_val_q;
  assign out_msg = out_msg_q;

  assign in_go   = in_val && in_rdy;
  assign out_go  = out_val_q && out_rdy;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cry_d     = cry_q;
    cnt_d     = cnt_q;
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    sum       = {1'b0, acc_q} + {1'b0, in_msg};

    case (state_q)
      ST_ACCUM: begin
        if (in_go) begin
          acc_d = sum[31:0];
          cry_d = cry_q | sum[32];
          cnt_d = cnt_q + cnt_w'(1);
          // Last term: load the completed sum straight into the output register.
          if (cnt_q == cnt_last) begin
            state_d   = ST_DONE;
            out_val_d = 1'b1;
            out_msg_d = {cry_q | sum[32], sum[31:0]};
          end
        end
      end

      ST_DONE: begin
        if (out_go) begin
          if (in_go) begin
            // Accepted product is term 1 of the next group.
            acc_d = in_msg;
            cry_d = 1'b0;
            cnt_d = cnt_w'(1);
            if (p_nterms == 1) begin
              out_val_d = 1'b1;
              out_msg_d = {1'b0, in_msg};
            end else begin
              state_d   = ST_ACCUM;
              out_val_d = 1'b0;
            end
          end else begin
            acc_d     = '0;
            cry_d     = 1'b0;
            cnt_d     = '0;
            state_d   = ST_ACCUM;
            out_val_d = 1'b0;
          end
        end
      end

      default: begin
        state_d   = ST_ACCUM;
        out_val_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cry_q     <= 1'b0;
      cnt_q     <= '0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cry_q     <= cry_d;
      cnt_q     <= cnt_d;
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
    end
  end

`ifndef SYNTHESIS
  handshake_known_a : assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_val, out_rdy, in_rdy, out_val}));
`endif

endmodule

// File: tb/tb_lab1_imul_dot_accum.sv
// tb/tb_lab1_imul_dot_accum.sv - self-checking bench for lab1_imul_dot_accum
module tb_lab1_imul_dot_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;

  logic        a_in_val = 1'b0;
  logic        a_in_rdy;
  logic [31:0] a_in_msg = '0;
  logic        a_out_val;
  logic        a_out_rdy = 1'b0;
  logic [32:0] a_out_msg;

  logic        b_in_val = 1'b0;
  logic        b_in_rdy;
  logic [31:0] b_in_msg = '0;
  logic        b_out_val;
  logic        b_out_rdy = 1'b0;
  logic [32:0] b_out_msg;

  lab1_imul_dot_accum #(.p_nterms(4)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .in_val  (a_in_val),
    .in_rdy  (a_in_rdy),
    .in_msg  (a_in_msg),
    .out_val (a_out_val),
    .out_rdy (a_out_rdy),
    .out_msg (a_out_msg)
  );

  lab1_imul_dot_accum #(.p_nterms(1)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .in_val  (b_in_val),
    .in_rdy  (b_in_rdy),
    .in_msg  (b_in_msg),
    .out_val (b_out_val),
    .out_rdy (b_out_rdy),
    .out_msg (b_out_msg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a group's result is the full-precision sum of its
  // products; carry is set when that sum does not fit in 32 bits.
  longint unsigned a_grp_sum = 0;
  int              a_grp_n   = 0;
  int              a_in_total = 0;
  logic [32:0]     a_exp_q[$];
  logic [32:0]     a_obs_q[$];

  int              b_in_total = 0;
  int              b_out_total = 0;
  logic [32:0]     b_exp_q[$];

  // Handshakes are observed at the falling edge; inputs only change just
  // after a rising edge, so what is seen here is what the next edge takes.
  always @(negedge clk) begin
    if (reset) begin
      a_grp_sum = 0;
      a_grp_n   = 0;
      a_exp_q.delete();
      b_exp_q.delete();
    end else begin
      if (a_out_val && a_out_rdy) begin
        a_obs_q.push_back(a_out_msg);
        if (a_exp_q.size() == 0) check("a_unexpected_out", a_exp_q.size(), 1);
        else check("a_group_sum", a_out_msg, a_exp_q.pop_front());
      end
      if (a_in_val && a_in_rdy) begin
        a_in_total++;
        a_grp_sum += a_in_msg;
        a_grp_n++;
        if (a_grp_n == 4) begin
          a_exp_q.push_back({a_grp_sum > 64'h0000_0000_FFFF_FFFF, a_grp_sum[31:0]});
          a_grp_sum = 0;
          a_grp_n   = 0;
        end
      end
      if (b_out_val && b_out_rdy) begin
        b_out_total++;
        if (b_exp_q.size() == 0) check("b_unexpected_out", b_exp_q.size(), 1);
        else check("b_echo", b_out_msg, b_exp_q.pop_front());
      end
      if (b_in_val && b_in_rdy) begin
        b_in_total++;
        b_exp_q.push_back({1'b0, b_in_msg});
      end
    end
  end

  int a_stalls = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [31:0] v);
    bit got;
    got = 1'b0;
    a_in_val = 1'b1;
    a_in_msg = v;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (a_in_rdy) got = 1'b1;
      else a_stalls++;
    end
    check("a_send_accepted", got, 1);
    tick();
    a_in_val = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int start;
    int cyc;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_in_rdy_low", a_in_rdy, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_val", a_out_val, 0);
    check("rst_out_msg", a_out_msg, 0);
    check("rst_in_rdy_high", a_in_rdy, 1);
    tick();

    // Basic group
    a_out_rdy = 1'b1;
    a_send(3); a_send(5); a_send(7); a_send(9);
    @(negedge clk);
    check("basic_out_val", a_out_val, 1);
    check("basic_out_msg", a_out_msg, 33'h0_0000_0018);
    tick();
    @(negedge clk);
    check("basic_out_val_one_cycle", a_out_val, 0);
    tick();

    // Carry, then carry cleared for the next group
    a_send(32'hFFFF_FFFF); a_send(32'h2); a_send(0); a_send(0);
    @(negedge clk);
    check("carry_out_msg", a_out_msg, 33'h1_0000_0001);
    tick();
    a_send(1); a_send(1); a_send(1); a_send(1);
    @(negedge clk);
    check("carry_cleared_msg", a_out_msg, 33'h0_0000_0004);
    tick();

    // Back-to-back with pipelined handoff
    a_stalls = 0;
    a_obs_q.delete();
    for (int i = 1; i <= 8; i++) a_send(32'(i));
    repeat (2) tick();
    check("b2b_no_stall", a_stalls, 0);
    check("b2b_count", a_obs_q.size(), 2);
    check("b2b_first", a_obs_q[0], 33'd10);
    check("b2b_second", a_obs_q[1], 33'd26);

    // Backpressure
    a_out_rdy = 1'b0;
    a_send(10); a_send(20); a_send(30); a_send(40);
    a_in_val = 1'b1;
    a_in_msg = 100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_rdy", a_in_rdy, 0);
      check("bp_out_val", a_out_val, 1);
      check("bp_out_msg", a_out_msg, 33'd100);
      tick();
    end
    a_obs_q.delete();
    a_out_rdy = 1'b1;
    a_send(100); a_send(1); a_send(2); a_send(3);
    repeat (2) tick();
    check("bp_count", a_obs_q.size(), 2);
    check("bp_first", a_obs_q[0], 33'd100);
    check("bp_next_group", a_obs_q[1], 33'd106);

    // Random gaps over 64 groups
    a_obs_q.delete();
    start = a_in_total;
    cyc = 0;
    while (cyc < 20000 && (a_in_total - start) < 256) begin
      a_in_val  = 1'($urandom_range(0, 1));
      a_out_rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a_in_msg = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else a_in_msg = $urandom();
      tick();
      cyc++;
    end
    a_in_val  = 1'b0;
    a_out_rdy = 1'b1;
    repeat (4) tick();
    check("rand_products", a_in_total - start, 256);
    check("rand_groups", a_obs_q.size(), 64);
    check("rand_drained", a_exp_q.size(), 0);

    // Reset mid-group
    a_send(5); a_send(6);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_rdy", a_in_rdy, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_val", a_out_val, 0);
    check("midrst_in_rdy_back", a_in_rdy, 1);
    tick();
    a_send(1); a_send(1); a_send(1); a_send(1);
    @(negedge clk);
    check("midrst_sum", a_out_msg, 33'd4);
    tick();

    // Reset while a sum is pending in DONE
    a_out_rdy = 1'b0;
    a_send(7); a_send(7); a_send(7); a_send(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("donerst_out_val", a_out_val, 0);
    check("donerst_out_msg", a_out_msg, 0);
    tick();
    a_out_rdy = 1'b1;

    // p_nterms = 1: each product is echoed with carry clear
    b_out_rdy = 1'b1;
    b_in_val  = 1'b1;
    b_in_msg  = 32'hFFFF_FFFF;
    tick();
    b_in_val  = 1'b0;
    @(negedge clk);
    check("n1_out_val", b_out_val, 1);
    check("n1_out_msg", b_out_msg, 33'h0_FFFF_FFFF);
    tick();
    for (int i = 0; i < 200; i++) begin
      b_in_val  = 1'($urandom_range(0, 1));
      b_out_rdy = 1'($urandom_range(0, 1));
      b_in_msg  = $urandom();
      tick();
    end
    b_in_val  = 1'b0;
    b_out_rdy = 1'b1;
    repeat (3) tick();
    check("n1_drained", b_exp_q.size(), 0);
    check("n1_in_out_balance", b_out_total, b_in_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lab1_imul_dot_accum.md
# lab1_imul_dot_accum

Downstream reduction stage for the lab1 integer multiplier. Consumes the multiplier's 32-bit result stream over a val/rdy interface, sums each group of `p_nterms` consecutive products, and emits one dot-product message per group. A sticky unsigned-carry flag accompanies each sum. Its input port connects directly to the multiplier's `resp_val`/`resp_rdy`/`resp_msg`.

## Interface

- `p_nterms`, default 4: products per group; legal range 1..256.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `in_val`  input  1: product valid (from multiplier `resp_val`).
- `in_rdy`  output  1: stage can accept a product (to multiplier `resp_rdy`).
- `in_msg`  input  32: product, the multiplier result message `result` field.
- `out_val`  output  1: group sum valid.
- `out_rdy`  input  1: consumer ready.
- `out_msg`  output  33: `{carry, sum[31:0]}`.

## Operation

- Transfer occurs on an edge where val and rdy are both 1: `in_go = in_val & in_rdy`, `out_go = out_val & out_rdy`.
- State: 2-state FSM (ACCUM, DONE), 32-bit accumulator `acc`, sticky `cry`, term counter `cnt` of width clog2(p_nterms)+1.
- ACCUM:
  - `in_rdy = 1`, `out_val = 0`.
  - On `in_go`: `{c, acc} <= acc + in_msg` (33-bit add); `cry <= cry | c`; `cnt <= cnt + 1`.
  - If `in_go` and `cnt == p_nterms-1`: go to DONE. The final addition is the one loaded into the output register.
- DONE:
  - `out_val = 1`; `out_msg = {cry, acc}`, held stable until `out_go`.
  - `in_rdy = out_rdy` (combinational path, pipelined handoff).
  - On `out_go` without `in_go`: `acc <= 0`, `cry <= 0`, `cnt <= 0`, go to ACCUM.
  - On `out_go` with `in_go`: the accepted product starts the next group: `acc <= in_msg`, `cry <= 0`, `cnt <= 1`. Go to ACCUM, or stay in DONE when `p_nterms == 1`.
  - No `in_go` can occur in DONE without `out_go`.
- Arithmetic: unsigned, modulo 2^32. `cry` records any carry out of bit 31 within the group. The sum of the low 32 bits is exact, so a signed consumer ignores `cry`.
- `in_msg` is sampled only on `in_go`. `out_rdy` has no effect in ACCUM.
- Outside reset, `in_val`, `out_rdy`, `in_rdy` and `out_val` must never be X; violations are flagged by a simulation-only assertion.

## Timing

- Reset, with `reset` high at an edge:
  - State goes to ACCUM; `acc`, `cry`, `cnt` clear to 0.
  - `out_val = 0` and `out_msg = 0` from the following cycle.
  - `in_rdy = 0` while `reset` is high; `in_rdy = 1` from the first cycle after reset deasserts.
- Reset mid-group or in DONE discards the partial or pending sum. No output transfer is generated for it.
- Latency: `out_val` rises the cycle after the edge that accepted the last term.
- Throughput:
  - With `out_rdy` held at 1, one group completes every `p_nterms` cycles with no bubble.
  - With `out_rdy = 0` in DONE, the stage stalls upstream (`in_rdy = 0`) indefinitely. `out_msg` is unchanged.
- Counter boundary: `cnt` never exceeds `p_nterms-1` in ACCUM. For `p_nterms = 256`, `cnt` reaches 255 without wrap.

## Test plan

- Basic group, `p_nterms=4`, `out_rdy=1`: products 3, 5, 7, 9 on consecutive cycles -> one output `{0, 0x00000018}`, `out_val` high exactly one cycle, first rising the cycle after the 4th transfer.
- Carry, `p_nterms=4`: products 0xFFFFFFFF, 0x00000002, 0, 0 -> `out_msg = {1, 0x00000001}`. The next group of 1, 1, 1, 1 -> `{0, 0x00000004}` (carry cleared).
- Back-to-back with pipelined handoff: 8 products 1..8 streamed every cycle, `out_rdy=1` -> outputs 10 then 26, no idle cycle on `in_rdy`.
- Backpressure:
  - `out_rdy=0` for 5 cycles after the group completes -> `in_rdy=0` and `out_msg` stable for those 5 cycles.
  - Raise `out_rdy` with `in_val=1` carrying 100 -> output transfers and 100 becomes term 1 of the next group.
- Random `in_val`/`out_rdy` gaps (50% each) over 64 groups -> every sum matches a scoreboard and no product is dropped or duplicated.
- Reset mid-group: accept 2 of 4 terms, assert `reset` one cycle -> `out_val=0`. The next 4 products 1, 1, 1, 1 -> `{0, 4}`. Also run with `p_nterms=1`: each product is echoed with `cry=0`.
